hbmc_bus_sync_tx: RTL and testbench
===================================

HBMC_BUS_SYNC_TX -- requirements
Module: hbmc_bus_sync_tx

Interface
REQ-001 Parameter C_DATA_WIDTH, default 8, is the width of the data word.
REQ-002 Parameter C_FIFO_DEPTH, default 4, is the number of buffered words; SHALL be a power of two, minimum 2.
REQ-003 Parameter C_TIMEOUT, default 1024, is the maximum ack-wait time in clk cycles; only used when HBMC_BUS_SYNC_TX_TIMEOUT_EN is defined.
REQ-004 clk  input  1  Single clock for all logic.
REQ-005 rst  input  1  Reset: synchronous and active-high.
REQ-006 s_data  input  C_DATA_WIDTH  Upstream word.
REQ-007 s_valid  input  1  Upstream word valid.
REQ-008 s_ready  output  1  Block can accept a word.
REQ-009 req_data  output  C_DATA_WIDTH  Word presented to the bus synchronizer source side.
REQ-010 req  output  1  Four-phase request to the bus synchronizer.
REQ-011 ack  input  1  Four-phase acknowledge, already synchronized into clk.
REQ-012 level  output  $clog2(C_FIFO_DEPTH)+1  Number of words currently buffered.
REQ-013 busy  output  1  High when the FIFO is non-empty or the FSM is not in IDLE.
REQ-014 err_timeout  output  1  Sticky ack-timeout flag.

Function
REQ-015 Transfer rule: a word SHALL be written on each rising edge with s_valid & s_ready.
REQ-016 s_ready SHALL equal ~full; there is no bypass when full, even if a pop occurs in the same cycle.
REQ-017 FIFO ordering: the FIFO SHALL be FIFO-ordered.
REQ-018 Pointer wrap: read and write pointers SHALL wrap modulo C_FIFO_DEPTH.
REQ-019 Level arithmetic: level SHALL count 0..C_FIFO_DEPTH.
REQ-020 Simultaneous push and pop SHALL leave level unchanged.
REQ-021 FSM states SHALL be IDLE, REQ and RELEASE.
REQ-022 IDLE: when the FIFO is non-empty and ack=0, the FSM SHALL pop one word, load it into req_data, set req=1 and go to REQ, all on one edge.
REQ-023 IDLE: when ack=1, the FSM SHALL wait; it never raises req while ack is high.
REQ-024 REQ: when ack=1, the FSM SHALL set req=0 and go to RELEASE.
REQ-025 REQ: req_data and req SHALL be held stable.
REQ-026 RELEASE: when ack=0, the FSM SHALL go to IDLE; req_data is held until this edge.
REQ-027 Latency: a word written into an empty FIFO with the FSM in IDLE and ack=0 at edge N SHALL appear with req=1 after edge N+1.
REQ-028 Throughput: with an ideal ack echo, back-to-back words SHALL be issued every 3 cycles plus the ack round-trip.
REQ-029 req_data SHALL change only on the IDLE->REQ edge.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL apply req=0, req_data=0, level=0, empty pointers, state IDLE and err_timeout=0.
REQ-031 While rst=1, s_ready SHALL be 0.
REQ-032 s_ready SHALL be 1 from the first edge with rst=0.
REQ-033 A reset mid-handshake SHALL drop req within one edge and discard buffered words.

Configuration
REQ-034 Macro HBMC_BUS_SYNC_TX_TIMEOUT_EN SHALL enable the ack-timeout feature.
REQ-035 With HBMC_BUS_SYNC_TX_TIMEOUT_EN defined, a cycle counter SHALL clear on every state change and count while in REQ or RELEASE.
REQ-036 With the macro defined, when the counter reaches C_TIMEOUT the block SHALL set err_timeout=1 (sticky until rst) and force req=0; the word in flight is dropped.
REQ-037 With the macro defined, after a timeout from REQ the FSM SHALL go to RELEASE; after a timeout from RELEASE it SHALL go to IDLE.
REQ-038 Without the macro, there SHALL be no counter logic, err_timeout SHALL be tied 0, and the FSM SHALL wait on ack indefinitely.

Verification
REQ-039 Reset then push 0xA5 with ack tied to req delayed 3 cycles -> req rises one edge after the push, req_data=0xA5 held until ack falls, level returns to 0.
REQ-040 Push 0x01..0x06 back-to-back with ack stuck 0, C_FIFO_DEPTH=4 -> 0x01 issued, 4 buffered, s_ready=0, 0x06 stalled; releasing ack delivers 0x01..0x06 in order.
REQ-041 ack=1 held in IDLE with FIFO non-empty -> req stays 0 until ack=0.
REQ-042 Assert rst while req=1 with level=3 -> req=0, level=0, state IDLE after one edge; no word is issued after rst drops.
REQ-043 With HBMC_BUS_SYNC_TX_TIMEOUT_EN defined and C_TIMEOUT=16, ack stuck 0 after a push -> after 16 cycles err_timeout=1, req=0; the next word issues normally and err_timeout stays 1.
REQ-044 Without the macro, ack stuck 0 for 5000 cycles -> req stays 1 and err_timeout=0.

Source files
------------

// File: rtl/hbmc_bus_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : hbmc_bus_sync_tx
// Description : Source side of a four-phase bus synchronizer. Upstream words
//               are buffered in a small FIFO. A three-state FSM
//               (IDLE/REQ/RELEASE) pops one word at a time and presents it on
//               req_data with a four-phase req/ack handshake.
//               Optional feature: define HBMC_BUS_SYNC_TX_TIMEOUT_EN to add an
//               ack-wait timeout with a sticky err_timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hbmc_bus_sync_tx #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_DATA_WIDTH-1:0]           s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [C_DATA_WIDTH-1:0]           req_data,
  output logic                              req,
  input  logic                              ack,
  output logic [$clog2(C_FIFO_DEPTH):0]     level,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int C_AW = $clog2(C_FIFO_DEPTH);
  localparam int C_LW = C_AW + 1;

  // The pointer arithmetic relies on natural binary wrap.
  if ((C_FIFO_DEPTH < 2) || ((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("hbmc_bus_sync_tx: C_FIFO_DEPTH must be a power of two >= 2");
  end
  if (C_TIMEOUT < 1) begin : g_bad_timeout
    $error("hbmc_bus_sync_tx: C_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [C_DATA_WIDTH-1:0]   r_mem [C_FIFO_DEPTH];
  logic [C_AW-1:0]           r_wr_ptr;
  logic [C_AW-1:0]           r_rd_ptr;
  logic [C_LW-1:0]           r_level;
  logic [C_DATA_WIDTH-1:0]   r_req_data;
  logic                      r_req;
  logic                      r_err_timeout;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_timeout;

  assign w_full  = (r_level == C_LW'(C_FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  // No bypass: a full FIFO refuses a word even if a pop happens this cycle.
  assign s_ready = ~w_full & ~rst;
  assign w_push  = s_valid & s_ready;
  // Never raise req while ack from the previous handshake is still high.
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty & ~ack;

`ifdef HBMC_BUS_SYNC_TX_TIMEOUT_EN
  localparam int C_CW = $clog2(C_TIMEOUT + 1);

  logic [C_CW-1:0] r_cnt;
  logic            w_leave;

  assign w_timeout = (r_state != ST_IDLE) && (r_cnt == C_CW'(C_TIMEOUT - 1));
  assign w_leave   = ((r_state == ST_REQ) && ack) ||
                     ((r_state == ST_RELEASE) && !ack) ||
                     w_timeout;

  // Ack-wait counter: zero in IDLE and on every state change, counts otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || w_leave) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign r_err_timeout = 1'b0;
`endif

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Handshake FSM; req_data is only loaded on the IDLE->REQ edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_req_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_req_data <= r_mem[r_rd_ptr];
            r_req      <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack || w_timeout) begin
            r_req   <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!ack || w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_data    = r_req_data;
  assign req         = r_req;
  assign level       = r_level;
  assign busy        = ~w_empty | (r_state != ST_IDLE);
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hbmc_bus_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hbmc_bus_sync_tx
// Description : Directed self-checking bench for hbmc_bus_sync_tx. Timeout
//               scenario follows HBMC_BUS_SYNC_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hbmc_bus_sync_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] req_data;
  logic       req;
  logic       ack;
  logic [2:0] level;
  logic       busy;
  logic       err_timeout;

  logic       ack_auto = 1'b0;
  logic       ack_man  = 1'b0;
  logic [2:0] ack_dly  = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;

  hbmc_bus_sync_tx #(
    .C_DATA_WIDTH(8),
    .C_FIFO_DEPTH(4),
    .C_TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .req_data   (req_data),
    .req        (req),
    .ack        (ack),
    .level      (level),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Far-side echo: ack follows req three cycles later.
  always @(posedge clk) ack_dly <= {ack_dly[1:0], req};
  assign ack = ack_auto ? ack_dly[2] : ack_man;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
    n_checks++; if (req_data !== 8'h00) begin n_fail++; $display("FAIL reset_req_data: got %h expected 00", req_data); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
    rst = 1'b0;
    step();
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_latency();
    ack_auto = 1'b1;
    push_word(8'hA5);                       // edge N
    n_checks++; if (level !== 3'd1 || req !== 1'b0) begin n_fail++; $display("FAIL lat_n: level %0d req %b expected 1 0", level, req); end
    step();                                 // N+1
    n_checks++; if (req !== 1'b1 || req_data !== 8'hA5) begin n_fail++; $display("FAIL lat_req_rise: req %b data %h expected 1 a5", req, req_data); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL lat_level_pop: got %0d expected 0", level); end
    repeat (3) step();                      // N+4
    n_checks++; if (ack !== 1'b1 || req !== 1'b1 || req_data !== 8'hA5) begin n_fail++; $display("FAIL lat_hold_req: ack %b req %b data %h expected 1 1 a5", ack, req, req_data); end
    step();                                 // N+5
    n_checks++; if (req !== 1'b0 || req_data !== 8'hA5 || busy !== 1'b1) begin n_fail++; $display("FAIL lat_release: req %b data %h busy %b expected 0 a5 1", req, req_data, busy); end
    repeat (3) step();                      // N+8
    n_checks++; if (ack !== 1'b0 || busy !== 1'b1 || req_data !== 8'hA5) begin n_fail++; $display("FAIL lat_ack_fall: ack %b busy %b data %h expected 0 1 a5", ack, busy, req_data); end
    step();                                 // N+9
    n_checks++; if (busy !== 1'b0 || level !== 3'd0 || req_data !== 8'hA5) begin n_fail++; $display("FAIL lat_idle: busy %b level %0d data %h expected 0 0 a5", busy, level, req_data); end
    ack_auto = 1'b0;
    ack_man  = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    logic       prev_req;
    logic       push_now;
    ack_man = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", i, s_ready); end
      push_word(8'(i));
    end
    n_checks++; if (level !== 3'd4 || s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: level %0d s_ready %b expected 4 0", level, s_ready); end
    n_checks++; if (req !== 1'b1 || req_data !== 8'h01) begin n_fail++; $display("FAIL fill_first: req %b data %h expected 1 01", req, req_data); end
    s_data  = 8'h06;
    s_valid = 1'b1;
    repeat (3) step();
    n_checks++; if (level !== 3'd4 || s_ready !== 1'b0 || req_data !== 8'h01) begin n_fail++; $display("FAIL fill_stall: level %0d s_ready %b data %h expected 4 0 01", level, s_ready, req_data); end
    exp = 8'h02;
    prev_req = 1'b1;
    for (int c = 0; c < 200 && exp <= 8'h06; c++) begin
      push_now = s_valid & s_ready;
      ack_man  = req;
      step();
      if (push_now) s_valid = 1'b0;
      if (req && !prev_req) begin
        n_checks++; if (req_data !== exp) begin n_fail++; $display("FAIL fill_order: got %h expected %h", req_data, exp); end
        exp = exp + 8'h01;
      end
      prev_req = req;
    end
    n_checks++; if (exp !== 8'h07) begin n_fail++; $display("FAIL fill_drain_count: next %h expected 07", exp); end
    repeat (6) begin ack_man = req; step(); end
    ack_man = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0 || level !== 3'd0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL fill_end: busy %b level %0d s_valid %b expected 0 0 0", busy, level, s_valid); end
  endtask

  task automatic test_ack_hold_idle();
    ack_man = 1'b1;
    push_word(8'h3C);
    repeat (5) begin
      step();
      n_checks++; if (req !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL hold_no_req: req %b level %0d expected 0 1", req, level); end
    end
    ack_man = 1'b0;
    step();
    n_checks++; if (req !== 1'b1 || req_data !== 8'h3C || level !== 3'd0) begin n_fail++; $display("FAIL hold_issue: req %b data %h level %0d expected 1 3c 0", req, req_data, level); end
    ack_man = 1'b1; step();
    ack_man = 1'b0; step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    ack_man = 1'b0;
    push_word(8'h10);
    push_word(8'h11);
    push_word(8'h12);
    push_word(8'h13);
    n_checks++; if (req !== 1'b1 || level !== 3'd3 || req_data !== 8'h10) begin n_fail++; $display("FAIL mid_pre: req %b level %0d data %h expected 1 3 10", req, level, req_data); end
    rst = 1'b1;
    step();
    n_checks++; if (req !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || req_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst: req %b level %0d busy %b data %h expected 0 0 0 00", req, level, busy, req_data); end
    rst = 1'b0;
    repeat (5) begin
      step();
      n_checks++; if (req !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL mid_after: req %b level %0d expected 0 0", req, level); end
    end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready: got %b expected 1", s_ready); end
  endtask

`ifdef HBMC_BUS_SYNC_TX_TIMEOUT_EN
  task automatic test_timeout();
    ack_man = 1'b0;
    push_word(8'h77);
    step();
    n_checks++; if (req !== 1'b1 || req_data !== 8'h77) begin n_fail++; $display("FAIL to_issue: req %b data %h expected 1 77", req, req_data); end
    repeat (15) step();
    n_checks++; if (req !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_before: req %b err %b expected 1 0", req, err_timeout); end
    step();
    n_checks++; if (req !== 1'b0 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_fire: req %b err %b expected 0 1", req, err_timeout); end
    push_word(8'h88);
    n_checks++; if (level !== 3'd1 || req !== 1'b0) begin n_fail++; $display("FAIL to_push: level %0d req %b expected 1 0", level, req); end
    step();
    n_checks++; if (req !== 1'b1 || req_data !== 8'h88 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_next: req %b data %h err %b expected 1 88 1", req, req_data, err_timeout); end
    ack_man = 1'b1; step();
    ack_man = 1'b0; step();
    step();
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_end: busy %b err %b expected 0 1", busy, err_timeout); end
  endtask
`else
  task automatic test_timeout();
    ack_man = 1'b0;
    push_word(8'h5A);
    step();
    n_checks++; if (req !== 1'b1 || req_data !== 8'h5A) begin n_fail++; $display("FAIL nto_issue: req %b data %h expected 1 5a", req, req_data); end
    repeat (5000) step();
    n_checks++; if (req !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL nto_wait: req %b err %b expected 1 0", req, err_timeout); end
    ack_man = 1'b1; step();
    ack_man = 1'b0; step();
    step();
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL nto_end: busy %b err %b expected 0 0", busy, err_timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_ack_hold_idle();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
